// File: rtl/key_press_reader.sv
// key_press_reader: debounced push-button front end.
// Each active-low KEY bit passes through a 2-flop synchroniser and then a debounce
// state machine. The outputs are a debounced level and 1-cycle press/release pulses.
// A 2-digit BCD counter counts KEY[0] presses for the HEX display drivers.
// Optional feature: define KEY_REPEAT_EN to get auto-repeat press pulses while a key is held.

module key_press_reader #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] KEY,
    input  logic              CLR_COUNT,
    output logic [N_KEYS-1:0] PRESSED,
    output logic [N_KEYS-1:0] PRESS_PULSE,
    output logic [N_KEYS-1:0] RELEASE_PULSE,
    output logic [7:0]        COUNT_BCD
);

    // Debounce counter holds at most DEBOUNCE_CYCLES-1, so this width never wraps.
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
`else
    // Repeat configuration has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    typedef enum logic [1:0] {
        StIdle,
        StPwait,
        StHeld,
        StRwait
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser: invert to active-high, two flops against metastability.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] meta_q, meta_d;
    logic [N_KEYS-1:0] sync_q, sync_d;

    // Next state of the synchroniser chain.
    always_comb begin
        meta_d = ~KEY;
        sync_d = meta_q;
    end

    // Synchroniser flops reset to the released state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce state machine.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_KEYS; i++) begin : gen_key
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
        logic            pressed_q, pressed_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            s;
`ifdef KEY_REPEAT_EN
        logic [RptW-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
        logic            rpt_first_q, rpt_first_d;
`endif

        assign s       = sync_q[i];
        assign cnt_inc = cnt_q + CntW'(1);

`ifdef KEY_REPEAT_EN
        assign rpt_inc    = rpt_q + RptW'(1);
        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
        assign rpt_target = rpt_first_q ? RptW'(REPEAT_PERIOD) : RptW'(REPEAT_DELAY);
`endif

        // Debounce next-state: a change is accepted only after DEBOUNCE_CYCLES stable samples.
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            pressed_d   = pressed_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
`ifdef KEY_REPEAT_EN
            // Repeat timer only survives while the key stays in HELD.
            rpt_d       = '0;
            rpt_first_d = 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (s) begin
                        state_d = StPwait;
                        cnt_d   = CntW'(1);
                    end
                end
                StPwait: begin
                    if (!s) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
                        state_d   = StHeld;
                        cnt_d     = '0;
                        pressed_d = 1'b1;
                        press_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHeld: begin
                    if (!s) begin
                        state_d = StRwait;
                        cnt_d   = CntW'(1);
                    end
`ifdef KEY_REPEAT_EN
                    else if (rpt_inc == rpt_target) begin
                        press_d     = 1'b1;
                        rpt_first_d = 1'b1;
                    end else begin
                        rpt_d       = rpt_inc;
                        rpt_first_d = rpt_first_q;
                    end
`endif
                end
                StRwait: begin
                    if (s) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        pressed_d = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                end
            endcase
        end

        // Debounce state, counter and registered outputs; reset discards any partial window.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q     <= StIdle;
                cnt_q       <= '0;
                pressed_q   <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
                rpt_q       <= '0;
                rpt_first_q <= 1'b0;
`endif
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                pressed_q   <= pressed_d;
                press_q     <= press_d;
                release_q   <= release_d;
`ifdef KEY_REPEAT_EN
                rpt_q       <= rpt_d;
                rpt_first_q <= rpt_first_d;
`endif
            end
        end

        assign PRESSED[i]       = pressed_q;
        assign PRESS_PULSE[i]   = press_q;
        assign RELEASE_PULSE[i] = release_q;
    end

    // ------------------------------------------------------------------
    // BCD press counter for KEY[0]; counts the registered press pulse.
    // ------------------------------------------------------------------
    logic [7:0] count_q, count_d;

    // BCD increment with carry and 99 -> 00 rollover; clear has priority.
    always_comb begin
        count_d = count_q;
        if (CLR_COUNT) begin
            count_d = 8'h00;
        end else if (PRESS_PULSE[0]) begin
            if (count_q[3:0] == 4'd9) begin
                count_d[3:0] = 4'd0;
                if (count_q[7:4] == 4'd9) begin
                    count_d[7:4] = 4'd0;
                end else begin
                    count_d[7:4] = count_q[7:4] + 4'd1;
                end
            end else begin
                count_d[3:0] = count_q[3:0] + 4'd1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT_BCD = count_q;

endmodule

// File: tb/tb_key_press_reader.sv
// Bench for key_press_reader with DEBOUNCE_CYCLES=8 (REPEAT_DELAY=16, REPEAT_PERIOD=4).
// Expected pulses are queued with their cycle numbers when a key is driven and
// matched against the DUT pulses every cycle.

module tb_key_press_reader;

    localparam int DC  = 8;
    localparam int RD  = 16;
    localparam int RP  = 4;
    localparam int LAT = DC + 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] KEY;
    logic       CLR_COUNT;
    logic [1:0] PRESSED;
    logic [1:0] PRESS_PULSE;
    logic [1:0] RELEASE_PULSE;
    logic [7:0] COUNT_BCD;

    key_press_reader #(
        .N_KEYS         (2),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .KEY          (KEY),
        .CLR_COUNT    (CLR_COUNT),
        .PRESSED      (PRESSED),
        .PRESS_PULSE  (PRESS_PULSE),
        .RELEASE_PULSE(RELEASE_PULSE),
        .COUNT_BCD    (COUNT_BCD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int key;
        bit rel;
    } ev_t;

    typedef struct {
        int         key;
        int         presses;
        logic [7:0] exp;
    } vec_t;

    ev_t sb[$];
    int  total     = 0;
    int  bad       = 0;
    int  cyc       = 0;
    int  model_cnt = 0;

    function automatic logic [7:0] to_bcd(int n);
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(int c, int k, bit r);
        ev_t e;
        e.cyc = c;
        e.key = k;
        e.rel = r;
        sb.push_back(e);
        if (!r && k == 0) model_cnt++;
    endtask

    // One clock: sample #1 after the edge and match pulses against the queue.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_pulse key=%0d rel=%0d: got none, required at cycle %0d",
                     sb[0].key, sb[0].rel, sb[0].cyc);
            void'(sb.pop_front());
        end
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                logic p;
                p = (r != 0) ? RELEASE_PULSE[k] : PRESS_PULSE[k];
                if (p === 1'b1) begin
                    total++;
                    if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].key == k
                        && sb[0].rel == bit'(r)) begin
                        void'(sb.pop_front());
                    end else begin
                        bad++;
                        $display("FAIL unexpected_pulse key=%0d rel=%0d cycle=%0d: got 1, required 0",
                                 k, r, cyc);
                    end
                end
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    // Clean press held for 'hold' cycles, then release and idle for 'after' cycles.
    task automatic press_release(int k, int hold, int after);
        int c;
        c = cyc;
        KEY[k] = 1'b0;
        push(c + LAT, k, 1'b0);
`ifdef KEY_REPEAT_EN
        // Repeats fire while the FSM is still in HELD (up to 2 cycles after the raw rise).
        for (int t = c + LAT + RD; t <= c + hold + 2; t += RP) push(t, k, 1'b0);
`endif
        run(hold);
        KEY[k] = 1'b1;
        push(c + hold + LAT, k, 1'b1);
        run(after);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, required finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        int   c;
        int   r;

        tbl[0] = '{0, 1,  8'h01};
        tbl[1] = '{1, 3,  8'h01};
        tbl[2] = '{0, 8,  8'h09};
        tbl[3] = '{0, 1,  8'h10};
        tbl[4] = '{0, 89, 8'h99};
        tbl[5] = '{0, 1,  8'h00};

        // Reset state.
        RST       = 1'b1;
        KEY       = 2'b11;
        CLR_COUNT = 1'b0;
        run(3);
        check("reset_pressed", {6'b0, PRESSED}, 8'h00);
        check("reset_press_pulse", {6'b0, PRESS_PULSE}, 8'h00);
        check("reset_release_pulse", {6'b0, RELEASE_PULSE}, 8'h00);
        check("reset_count", COUNT_BCD, 8'h00);
        RST = 1'b0;
        run(2);

        // Clean press, hold 20 cycles, release.
        c = cyc;
        KEY[0] = 1'b0;
        push(c + LAT, 0, 1'b0);
        run(11);
        check("clean_pressed", {6'b0, PRESSED}, 8'h01);
        check("clean_count", COUNT_BCD, 8'h01);
        run(9);
        KEY[0] = 1'b1;
        push(c + 20 + LAT, 0, 1'b1);
        run(11);
        check("clean_released", {6'b0, PRESSED}, 8'h00);
        run(3);

        // Bounce every 3 cycles, final edge leaves the key pressed.
        c = cyc;
        push(c + 30 + LAT, 0, 1'b0);
        for (int j = 0; j < 11; j++) begin
            KEY[0] = ~KEY[0];
            run(3);
        end
        run(11);
        check("bounce_pressed", {6'b0, PRESSED}, 8'h01);
        check("bounce_count", COUNT_BCD, to_bcd(model_cnt));
        KEY[0] = 1'b1;
        push(cyc + LAT, 0, 1'b1);
        run(12);

        // Reset in the middle of a KEY[1] debounce window.
        c = cyc;
        KEY[1] = 1'b0;
        run(8);
        RST = 1'b1;
        #1;
        check("async_rst_count", COUNT_BCD, 8'h00);
        check("async_rst_pressed", {6'b0, PRESSED}, 8'h00);
        model_cnt = 0;
        run(2);
        RST = 1'b0;
        r = cyc;
        push(r + LAT, 1, 1'b0);
        run(12);
        check("post_rst_pressed", {6'b0, PRESSED}, 8'h02);
        KEY[1] = 1'b1;
        push(r + 12 + LAT, 1, 1'b1);
        run(14);

        // Both keys together.
        c = cyc;
        KEY = 2'b00;
        push(c + LAT, 0, 1'b0);
        push(c + LAT, 1, 1'b0);
        run(12);
        check("both_pressed", {6'b0, PRESSED}, 8'h03);
        KEY = 2'b11;
        push(c + 12 + LAT, 0, 1'b1);
        push(c + 12 + LAT, 1, 1'b1);
        run(14);
        check("both_count", COUNT_BCD, to_bcd(model_cnt));

        // BCD count table.
        CLR_COUNT = 1'b1;
        run(1);
        CLR_COUNT = 1'b0;
        model_cnt = 0;
        check("clr_count", COUNT_BCD, 8'h00);
        for (int i = 0; i < 6; i++) begin
            repeat (tbl[i].presses) press_release(tbl[i].key, 12, 12);
            check("bcd_table", COUNT_BCD, tbl[i].exp);
            check("bcd_model", COUNT_BCD, to_bcd(model_cnt));
        end

        // Clear coincident with a press pulse.
        press_release(0, 12, 12);
        check("pre_clr_count", COUNT_BCD, 8'h01);
        c = cyc;
        KEY[0] = 1'b0;
        push(c + LAT, 0, 1'b0);
        run(LAT);
        CLR_COUNT = 1'b1;
        run(1);
        CLR_COUNT = 1'b0;
        model_cnt = 0;
        check("clr_vs_inc", COUNT_BCD, 8'h00);
        run(1);
        KEY[0] = 1'b1;
        push(c + 12 + LAT, 0, 1'b1);
        run(14);
        check("clr_vs_inc_after", COUNT_BCD, 8'h00);

        // Long hold: auto-repeat when enabled, a single pulse otherwise.
        CLR_COUNT = 1'b1;
        run(1);
        CLR_COUNT = 1'b0;
        model_cnt = 0;
        press_release(0, LAT + 40, 14);
`ifdef KEY_REPEAT_EN
        check("repeat_count", COUNT_BCD, 8'h08);
`else
        check("long_hold_count", COUNT_BCD, 8'h01);
`endif
        check("long_hold_model", COUNT_BCD, to_bcd(model_cnt));
        check("long_hold_released", {6'b0, PRESSED}, 8'h00);

        run(4);
        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL leftover_pulse key=%0d rel=%0d: got none, required at cycle %0d",
                     sb[0].key, sb[0].rel, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
